lc3b_pipe_skid_reg: RTL and testbench
=====================================

# lc3b_pipe_skid_reg

Parametrised, elastic pipeline-stage register for the LC-3b pipeline. It replaces the fixed, always-loading stage flip-flops with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. Upstream stalls can then propagate without a combinational path, and branch squashes can kill in-flight instructions. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage payload packed into `in_data`.

## Interface
Parameters:
- DATA_W, default 64: payload width in bits (packed stage bundle: words, control word, dest reg).
- CNT_W, default 16: stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  block can accept; driven only from state flops.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous squash of all held and incoming payloads.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload to next stage; driven from the main register.
- stall_count  out  CNT_W  cycles with `out_valid & !out_ready`, saturating.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage:
  - main register (main_v, main_d) drives the outputs.
  - skid register (skid_v, skid_d).
- State is encoded by the valid bits:
  - EMPTY: !main_v.
  - FULL: main_v & !skid_v.
  - SKID: main_v & skid_v.
- Outputs: out_valid = main_v; in_ready = !skid_v.
- EMPTY:
  - in_fire -> FULL, main_d <= in_data.
  - otherwise stay EMPTY.
- FULL:
  - in_fire & out_fire -> FULL, main_d <= in_data.
  - in_fire & !out_fire -> SKID, skid_d <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- SKID (in_ready = 0):
  - out_fire -> FULL, main_d <= skid_d.
  - otherwise hold.
- flush has top priority. Next state is EMPTY with main_v = skid_v = 0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes; downstream sampled a valid payload.
  - Data registers need not change on flush.
- While out_valid & !out_ready, out_data is held bit-stable.
- stall_count:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Not cleared by flush; cleared only by reset.
- Reset (asynchronous, any cycle, including mid-transfer):
  - main_v = skid_v = 0, main_d = skid_d = 0, stall_count = 0.
  - Hence out_valid = 0, in_ready = 1, out_data = 0.
  - After reset deasserts, the first in_fire is accepted normally.

## Timing
- Latency: in_fire at edge N gives out_valid with that payload after edge N (visible in cycle N+1).
- Throughput: 1 payload/cycle when out_ready is held high; no bubbles.
- in_ready depends only on flops: no combinational path from out_ready or flush to in_ready.
- out_valid and out_data are register outputs: no combinational path from any input.
- Backpressure: in_ready falls one cycle after the first un-accepted output. The skid entry absorbs the payload upstream launched in that cycle.
- Ordering: strictly FIFO, at most 2 payloads held. None dropped except by flush.

## Structure
- `lc3b_types` package gains:
  - `pipe_state_t` enum {PIPE_EMPTY, PIPE_FULL, PIPE_SKID}, used for assertions and debug, derived from the valid bits.
  - Per-stage bundle structs (e.g. `lc3b_ex_mem_bundle`: adder word, alu word, control word, dest reg), so each instance sets DATA_W = $bits(bundle).
- Consumers derive memory strobes at the stage output as ctrl.mem_read & out_valid and ctrl.mem_write & out_valid. This keeps squashed instructions from reaching memory.
- One natural sub-module: `lc3b_sat_counter` (param W; inputs inc, reset; saturating count) for stall_count.
- Everything else is flat in one always_ff with async reset plus combinational next-state logic.

## Test plan
- Reset mid-stream:
  - Stimulus: fill to SKID with 0x11, 0x22; assert reset for 1 cycle.
  - Response: immediately out_valid=0, out_data=0, in_ready=1, stall_count=0. After release, 0x33 in emerges next cycle.
- Streaming: out_ready=1, in_valid=1, data 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, one cycle late; stall_count stays 0.
- Backpressure:
  - Stimulus: stream 0xA,0xB,0xC; drop out_ready for 3 cycles after 0xA appears.
  - Response: in_ready=0 from the 2nd stalled cycle; 0xA held stable; then 0xA,0xB,0xC delivered in order; stall_count=3.
- Flush:
  - Stimulus: in SKID state (0x5 main, 0x6 skid), assert flush together with in_valid carrying 0x7.
  - Response: next cycle out_valid=0, in_ready=1; 0x5, 0x6 and 0x7 never appear.
- Flush with out_fire: in FULL with 0x9, flush=1 and out_ready=1 together -> 0x9 counted as delivered that cycle; next cycle EMPTY.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_count stops at 15 and stays 15.

Source files
------------

// File: rtl/lc3b_pipe_skid_reg_pkg.sv
// Shared LC-3b pipeline types: stage-register state and stage bundles.
// Each stage-boundary instance sizes its payload with $bits(bundle).
package lc3b_types;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ld_regfile;
    logic       ld_cc;
    logic [3:0] aluop;
    logic [1:0] wb_mux;
  } lc3b_ctrl_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } lc3b_if_id_bundle;

  typedef struct packed {
    logic [15:0] adder;
    logic [15:0] alu;
    lc3b_ctrl_t  ctrl;
    logic [2:0]  dest;
  } lc3b_ex_mem_bundle;

  // Squashed stages must never strobe memory.
  function automatic logic [1:0] mem_strobes(
    input lc3b_ctrl_t ctrl,
    input logic       valid
  );
    return {ctrl.mem_read & valid, ctrl.mem_write & valid};
  endfunction

endpackage

// File: rtl/lc3b_pipe_skid_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module lc3b_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/lc3b_pipe_skid_reg.sv
// Elastic stage register: valid/ready handshake, one-entry skid,
// synchronous flush and a saturating stall counter.
module lc3b_pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);
  import lc3b_types::*;

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              main_v_n, skid_v_n;
  logic [DATA_W-1:0] main_d_n, skid_d_n;
  logic              in_fire, out_fire;
  pipe_state_t       state;

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_ready  = !skid_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state = PIPE_EMPTY;
    if (main_v) state = skid_v ? PIPE_SKID : PIPE_FULL;
  end

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_d_n = main_d;
    skid_d_n = skid_d;
    unique case (state)
      PIPE_EMPTY: begin
        if (in_fire) begin
          main_v_n = 1'b1;
          main_d_n = in_data;
        end
      end
      PIPE_FULL: begin
        if (in_fire && out_fire) begin
          main_d_n = in_data;
        end else if (in_fire) begin
          skid_v_n = 1'b1;
          skid_d_n = in_data;
        end else if (out_fire) begin
          main_v_n = 1'b0;
        end
      end
      PIPE_SKID: begin
        if (out_fire) begin
          skid_v_n = 1'b0;
          main_d_n = skid_d;
        end
      end
      default: ;
    endcase
    // Squash wins; an out_fire this cycle has already been sampled.
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_d <= main_d_n;
      skid_d <= skid_d_n;
    end
  end

  lc3b_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (main_v & !out_ready),
    .count(stall_count)
  );

endmodule

// File: tb/tb_lc3b_pipe_skid_reg.sv
// Randomized + directed bench for lc3b_pipe_skid_reg against a queue model.
module tb_lc3b_pipe_skid_reg;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q[$];
  int            m_cnt = 0;

  lc3b_pipe_skid_reg #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // Model: FIFO of at most two payloads, stall counter saturating at 2^CW-1.
  task automatic model_step();
    bit ofire, ifire;
    ofire = (q.size() > 0) && out_ready;
    ifire = in_valid && (q.size() < 2);
    if ((q.size() > 0) && !out_ready && (m_cnt < (1 << CW) - 1)) m_cnt++;
    if (ofire) void'(q.pop_front());
    if (ifire) q.push_back(in_data);
    if (flush) q.delete();
  endtask

  task automatic cycle(input logic iv, input logic [DW-1:0] id,
                       input logic orr, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_stall", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Reset mid-stream from SKID
    cycle(1, 16'h11, 0, 0);
    cycle(1, 16'h22, 0, 0);
    @(negedge clk);
    check("skid_in_ready", 32'(in_ready), 32'd0);
    #1;
    do_reset();
    cycle(1, 16'h33, 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Streaming
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, DW'(i), 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    check("stream_stall", 32'(stall_count), 32'd0);

    // Backpressure
    do_reset();
    cycle(1, 16'hA, 1, 0);
    cycle(1, 16'hB, 0, 0);
    cycle(1, 16'hC, 0, 0);
    cycle(1, 16'hC, 0, 0);
    cycle(1, 16'hC, 1, 0);
    cycle(1, 16'hC, 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    check("bp_stall", 32'(stall_count), 32'd3);

    // Flush from SKID with incoming payload
    do_reset();
    cycle(1, 16'h5, 0, 0);
    cycle(1, 16'h6, 0, 0);
    cycle(1, 16'h7, 0, 1);
    check("flush_q", 32'(q.size()), 32'd0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Flush coinciding with out_fire
    do_reset();
    cycle(1, 16'h9, 0, 0);
    cycle(0, 16'h0, 1, 1);
    cycle(0, 16'h0, 1, 0);

    // Saturation
    do_reset();
    cycle(1, 16'h1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 16'h0, 0, 0);
    check("sat_stall", 32'(stall_count), 32'd15);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, DW'($urandom),
            ($urandom % 3) != 0, ($urandom % 20) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
